inst_fifo_arbiter: RTL and testbench
====================================

INST_FIFO_ARBITER -- requirements
Module: inst_fifo_arbiter

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 4, number of per-thread instruction FIFOs served (power of two, 2..8).
REQ-002 SHALL have parameter WIDTH, default 32, instruction/postfix word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port thread_en  input  NUM_THREADS  thread may issue when 1.
REQ-006 SHALL have port thread_flush  input  NUM_THREADS  synchronous rollback of thread t; the same signal drives that FIFO's flush_en.
REQ-007 SHALL have port fifo_empty  input  NUM_THREADS  per-FIFO empty flag.
REQ-008 SHALL have port fifo_almost_empty  input  NUM_THREADS  per-FIFO count<=1 flag (threshold 1).
REQ-009 SHALL have port fifo_head  input  NUM_THREADS x WIDTH  combinational head word of each FIFO.
REQ-010 SHALL have port head_postfix  input  NUM_THREADS  head word of FIFO t is followed by a postfix immediate.
REQ-011 SHALL have port fifo_dequeue_en  output  NUM_THREADS  one-hot-or-zero dequeue strobe.
REQ-012 SHALL have port issue_valid  output  1  issue register holds an instruction.
REQ-013 SHALL have port issue_ready  input  1  downstream accepts when issue_valid & issue_ready.
REQ-014 SHALL have port issue_thread  output  clog2(NUM_THREADS)  thread of the held instruction.
REQ-015 SHALL have port issue_inst  output  WIDTH  held instruction word.
REQ-016 SHALL have port issue_postfix_valid  output  1  issue_postfix is meaningful.
REQ-017 SHALL have port issue_postfix  output  WIDTH  held postfix immediate.
REQ-018 SHALL have port issue_count  output  32  wrapping count of accepted issues.

Function
REQ-019 SHALL implement states IDLE and POSTFIX.
REQ-020 SHALL treat thread t as eligible when thread_en[t] & !thread_flush[t] & !fifo_empty[t] & (!head_postfix[t] | !fifo_almost_empty[t]).
REQ-021 SHALL define slot_free = !issue_valid | issue_ready.
REQ-022 SHALL, in IDLE with slot_free, grant the first eligible thread searching round-robin from last_grant+1 modulo NUM_THREADS.
REQ-023 SHALL, on grant, assert fifo_dequeue_en[t] combinationally in the same cycle, capture fifo_head[t] into issue_inst, load issue_thread=t and set last_grant=t.
REQ-024 SHALL, on grant of a non-postfix head, set issue_valid=1 and issue_postfix_valid=0 next cycle; state stays IDLE; issue rate is 1 per cycle.
REQ-025 SHALL, on grant of a postfix head, set issue_valid=0 next cycle and go to POSTFIX.
REQ-026 SHALL, in POSTFIX without thread_flush[issue_thread], assert fifo_dequeue_en[issue_thread], capture fifo_head into issue_postfix, set issue_valid=1 and issue_postfix_valid=1, and return to IDLE; no new grant is made that cycle.
REQ-027 SHALL, in POSTFIX with thread_flush[issue_thread], not dequeue, leave issue_valid=0 and return to IDLE.
REQ-028 SHALL clear issue_valid next cycle when thread_flush[issue_thread] is 1 while issue_valid=1, regardless of issue_ready; issue_count is not incremented.
REQ-029 SHALL clear issue_valid on acceptance when no grant occurs in the same cycle.
REQ-030 SHALL increment issue_count by 1 per accepted transfer (issue_valid & issue_ready & !thread_flush[issue_thread]), wrapping at 2^32.
REQ-031 SHALL hold issue_* stable while issue_valid & !issue_ready.
REQ-032 SHALL never assert more than one fifo_dequeue_en bit, and never dequeue an empty FIFO.

Reset
REQ-033 SHALL, on reset=0, asynchronously set state=IDLE, last_grant=NUM_THREADS-1, issue_valid=0, issue_postfix_valid=0, issue_thread=0, issue_inst=0, issue_postfix=0, issue_count=0; fifo_dequeue_en=0 while reset is asserted.
REQ-034 SHALL, on reset asserted in POSTFIX, abandon the postfix fetch; the instruction already dequeued is lost (FIFOs are reset together).

Verification
REQ-035 SHALL cover: all four FIFOs non-empty, no postfix, issue_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; issue_count=5 after five accepts.
REQ-036 SHALL cover: thread 1 head_postfix=1, inst 0x1111_0001 then 0x0000_ABCD -> two dequeue cycles, then issue_valid=1, issue_inst=0x1111_0001, issue_postfix=0x0000_ABCD, issue_postfix_valid=1.
REQ-037 SHALL cover: head_postfix=1 with fifo_almost_empty=1 -> thread skipped, no dequeue, until a second entry arrives.
REQ-038 SHALL cover: issue_ready=0 for 3 cycles with issue_valid=1 -> outputs stable, no dequeue, issue_count unchanged.
REQ-039 SHALL cover: thread_flush[2] in POSTFIX for thread 2 -> single dequeue only, issue_valid stays 0, state returns to IDLE.
REQ-040 SHALL cover: reset driven low mid-POSTFIX -> all outputs return to REQ-033 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/inst_fifo_arbiter.sv
// Round-robin issue arbiter over per-thread instruction FIFOs. A head word
// flagged as carrying a postfix immediate is issued together with that immediate.
//
//   state   | meaning
//   IDLE    | arbitrate and issue one instruction per cycle
//   POSTFIX | fetch the immediate that follows the instruction just granted
module inst_fifo_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int WIDTH       = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_THREADS-1:0]                thread_en,
    input  logic [NUM_THREADS-1:0]                thread_flush,
    input  logic [NUM_THREADS-1:0]                fifo_empty,
    input  logic [NUM_THREADS-1:0]                fifo_almost_empty,
    input  logic [NUM_THREADS-1:0][WIDTH-1:0]     fifo_head,
    input  logic [NUM_THREADS-1:0]                head_postfix,
    output logic [NUM_THREADS-1:0]                fifo_dequeue_en,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [$clog2(NUM_THREADS)-1:0]        issue_thread,
    output logic [WIDTH-1:0]                      issue_inst,
    output logic                                  issue_postfix_valid,
    output logic [WIDTH-1:0]                      issue_postfix,
    output logic [31:0]                           issue_count
);

    localparam int TW = $clog2(NUM_THREADS);

    typedef enum logic {
        IDLE    = 1'b0,
        POSTFIX = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     last_grant_q, last_grant_d;
    logic              valid_q, valid_d;
    logic              pvalid_q, pvalid_d;
    logic [TW-1:0]     thread_q, thread_d;
    logic [WIDTH-1:0]  inst_q, inst_d;
    logic [WIDTH-1:0]  postfix_q, postfix_d;
    logic [31:0]       count_q, count_d;

    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] deq;
    logic                   grant_found;
    logic [TW-1:0]          grant_idx;
    logic [TW-1:0]          cand;
    logic                   slot_free;
    logic                   flush_cur;
    logic                   accept;

    // A postfix head needs its immediate already present before it may be granted.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = thread_en[t] & ~thread_flush[t] & ~fifo_empty[t]
                        & (~head_postfix[t] | ~fifo_almost_empty[t]);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_THREADS; i++) begin
            cand = last_grant_q + TW'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign slot_free = ~valid_q | issue_ready;
    assign flush_cur = thread_flush[thread_q];
    assign accept    = valid_q & issue_ready & ~flush_cur;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        valid_d      = valid_q;
        pvalid_d     = pvalid_q;
        thread_d     = thread_q;
        inst_d       = inst_q;
        postfix_d    = postfix_q;
        count_d      = accept ? count_q + 32'd1 : count_q;
        deq          = '0;

        case (state_q)
            IDLE: begin
                if (valid_q && (issue_ready || flush_cur)) begin
                    valid_d  = 1'b0;
                    pvalid_d = 1'b0;
                end
                if (slot_free && grant_found) begin
                    deq[grant_idx] = 1'b1;
                    inst_d         = fifo_head[grant_idx];
                    thread_d       = grant_idx;
                    last_grant_d   = grant_idx;
                    pvalid_d       = 1'b0;
                    if (head_postfix[grant_idx]) begin
                        valid_d = 1'b0;
                        state_d = POSTFIX;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            POSTFIX: begin
                if (flush_cur) begin
                    state_d = IDLE;
                end else if (!fifo_empty[thread_q]) begin
                    deq[thread_q] = 1'b1;
                    postfix_d     = fifo_head[thread_q];
                    valid_d       = 1'b1;
                    pvalid_d      = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= TW'(NUM_THREADS - 1);
            valid_q      <= 1'b0;
            pvalid_q     <= 1'b0;
            thread_q     <= '0;
            inst_q       <= '0;
            postfix_q    <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            valid_q      <= valid_d;
            pvalid_q     <= pvalid_d;
            thread_q     <= thread_d;
            inst_q       <= inst_d;
            postfix_q    <= postfix_d;
            count_q      <= count_d;
        end
    end

    // Reset also gates the strobe: in reset the arbiter looks idle and would otherwise grant.
    assign fifo_dequeue_en     = reset ? deq : '0;
    assign issue_valid         = valid_q;
    assign issue_thread        = thread_q;
    assign issue_inst          = inst_q;
    assign issue_postfix_valid = pvalid_q;
    assign issue_postfix       = postfix_q;
    assign issue_count         = count_q;

endmodule

// File: tb/tb_inst_fifo_arbiter.sv
// Bench for inst_fifo_arbiter: queue-backed FIFO environment, directed scenarios,
// then randomized traffic against a transaction-level reference model.
module tb_inst_fifo_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] w;
        logic         pf;
    } ent_t;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [N-1:0]          thread_en = '0;
    logic [N-1:0]          thread_flush = '0;
    logic [N-1:0]          fifo_empty;
    logic [N-1:0]          fifo_almost_empty;
    logic [N-1:0][W-1:0]   fifo_head;
    logic [N-1:0]          head_postfix;
    logic [N-1:0]          fifo_dequeue_en;
    logic                  issue_valid;
    logic                  issue_ready = 1'b0;
    logic [1:0]            issue_thread;
    logic [W-1:0]          issue_inst;
    logic                  issue_postfix_valid;
    logic [W-1:0]          issue_postfix;
    logic [31:0]           issue_count;

    always #5 clk = ~clk;

    inst_fifo_arbiter #(.NUM_THREADS(N), .WIDTH(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .thread_en          (thread_en),
        .thread_flush       (thread_flush),
        .fifo_empty         (fifo_empty),
        .fifo_almost_empty  (fifo_almost_empty),
        .fifo_head          (fifo_head),
        .head_postfix       (head_postfix),
        .fifo_dequeue_en    (fifo_dequeue_en),
        .issue_valid        (issue_valid),
        .issue_ready        (issue_ready),
        .issue_thread       (issue_thread),
        .issue_inst         (issue_inst),
        .issue_postfix_valid(issue_postfix_valid),
        .issue_postfix      (issue_postfix),
        .issue_count        (issue_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    ent_t q[N][$];

    // reference model: the held issue record plus a pending-immediate flag
    bit           m_valid, m_pvalid, m_wait;
    int           m_thread, m_last;
    logic [W-1:0] m_inst, m_post;
    logic [31:0]  m_count;
    logic [N-1:0] obs_deq;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_sigs();
        for (int t = 0; t < N; t++) begin
            fifo_empty[t]        = (q[t].size() == 0);
            fifo_almost_empty[t] = (q[t].size() <= 1);
            fifo_head[t]         = (q[t].size() > 0) ? q[t][0].w : '0;
            head_postfix[t]      = (q[t].size() > 0) ? q[t][0].pf : 1'b0;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pvalid = 0; m_wait = 0;
        m_thread = 0; m_last = N - 1;
        m_inst = '0; m_post = '0; m_count = '0;
    endtask

    function automatic bit elig(int t);
        return thread_en[t] && !thread_flush[t] && q[t].size() > 0
               && (!q[t][0].pf || q[t].size() >= 2);
    endfunction

    task automatic push(int t, logic [W-1:0] w, logic pf);
        ent_t e;
        e.w = w; e.pf = pf;
        q[t].push_back(e);
    endtask

    // one clock: check DUT against model at the falling edge, advance model and FIFOs
    task automatic cycle();
        logic [N-1:0] edeq;
        int           g;
        bit           fl;
        edeq = '0;
        g    = -1;
        @(negedge clk);
        fl = thread_flush[m_thread];
        if (m_wait) begin
            if (!fl && q[m_thread].size() > 0) edeq[m_thread] = 1'b1;
        end else if (!m_valid || issue_ready) begin
            for (int k = 1; k <= N; k++) begin
                int t;
                t = (m_last + k) % N;
                if (g < 0 && elig(t)) g = t;
            end
            if (g >= 0) edeq[g] = 1'b1;
        end
        obs_deq = fifo_dequeue_en;
        chk("dequeue_en", fifo_dequeue_en, edeq);
        chk("issue_valid", issue_valid, m_valid);
        chk("issue_count", issue_count, m_count);
        if (m_valid) begin
            chk("issue_thread", issue_thread, m_thread);
            chk("issue_inst", issue_inst, m_inst);
            chk("issue_postfix_valid", issue_postfix_valid, m_pvalid);
            if (m_pvalid) chk("issue_postfix", issue_postfix, m_post);
        end

        if (m_valid && issue_ready && !fl) m_count = m_count + 1;
        if (m_wait) begin
            if (fl) m_wait = 0;
            else if (q[m_thread].size() > 0) begin
                m_post = q[m_thread][0].w; m_valid = 1; m_pvalid = 1; m_wait = 0;
            end
        end else begin
            if (m_valid && (issue_ready || fl)) m_valid = 0;
            if (g >= 0) begin
                m_thread = g; m_last = g; m_inst = q[g][0].w; m_pvalid = 0;
                m_wait   = q[g][0].pf;
                m_valid  = !q[g][0].pf;
            end
        end

        @(posedge clk);
        for (int t = 0; t < N; t++) begin
            if (edeq[t]) void'(q[t].pop_front());
            if (thread_flush[t]) q[t].delete();
        end
        #1;
        update_sigs();
    endtask

    task automatic flush_all();
        thread_flush = '1;
        update_sigs();
        cycle();
        thread_flush = '0;
        update_sigs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        update_sigs();
        #12;
        chk("rst_deq", fifo_dequeue_en, 4'b0000);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", issue_valid, 0);
        chk("rst_pvalid", issue_postfix_valid, 0);
        chk("rst_thread", issue_thread, 0);
        chk("rst_inst", issue_inst, 0);
        chk("rst_postfix", issue_postfix, 0);
        chk("rst_count", issue_count, 0);

        // round robin over four loaded FIFOs
        for (int t = 0; t < N; t++) begin
            push(t, 32'h1000 + 32'(t * 16), 1'b0);
            push(t, 32'h1001 + 32'(t * 16), 1'b0);
        end
        thread_en = 4'b1111; issue_ready = 1'b1;
        update_sigs();
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            cycle();
            chk("rr_grant", obs_deq, exp_g);
        end
        thread_en = '0; update_sigs();
        cycle();
        chk("rr_count5", issue_count, 5);
        flush_all();

        // postfix pair on thread 1
        push(1, 32'h1111_0001, 1'b1);
        push(1, 32'h0000_ABCD, 1'b0);
        thread_en = 4'b0010; update_sigs();
        cycle(); chk("pf_deq_inst", obs_deq, 4'b0010);
        chk("pf_wait_valid", issue_valid, 0);
        cycle(); chk("pf_deq_imm", obs_deq, 4'b0010);
        chk("pf_valid", issue_valid, 1);
        chk("pf_inst", issue_inst, 32'h1111_0001);
        chk("pf_postfix", issue_postfix, 32'h0000_ABCD);
        chk("pf_pvalid", issue_postfix_valid, 1);

        // postfix head without its immediate yet
        push(2, 32'h2222_0002, 1'b1);
        thread_en = 4'b0100; update_sigs();
        repeat (3) begin
            cycle(); chk("ae_skip", obs_deq, 4'b0000);
        end
        push(2, 32'h0000_5555, 1'b0); update_sigs();
        cycle(); chk("ae_deq_inst", obs_deq, 4'b0100);
        cycle(); chk("ae_deq_imm", obs_deq, 4'b0100);
        chk("ae_postfix", issue_postfix, 32'h0000_5555);

        // back-pressure
        push(0, 32'hCAFE_0000, 1'b0);
        push(0, 32'hCAFE_0001, 1'b0);
        push(0, 32'hCAFE_0002, 1'b0);
        thread_en = 4'b0001; update_sigs();
        cycle();
        issue_ready = 1'b0;
        repeat (3) begin
            cycle();
            chk("stall_deq", obs_deq, 4'b0000);
            chk("stall_valid", issue_valid, 1);
            chk("stall_inst", issue_inst, 32'hCAFE_0000);
            chk("stall_count", issue_count, 7);
        end
        issue_ready = 1'b1;
        cycle(); chk("stall_release", obs_deq, 4'b0001);
        thread_en = '0; update_sigs();
        repeat (2) cycle();
        flush_all();

        // flush while fetching the immediate
        push(2, 32'h3333_0003, 1'b1);
        push(2, 32'h0000_7777, 1'b0);
        thread_en = 4'b0100; update_sigs();
        cycle(); chk("fp_deq_inst", obs_deq, 4'b0100);
        thread_flush = 4'b0100; update_sigs();
        cycle(); chk("fp_no_deq", obs_deq, 4'b0000);
        chk("fp_valid", issue_valid, 0);
        thread_flush = '0; update_sigs();
        cycle(); chk("fp_valid_after", issue_valid, 0);
        push(2, 32'h4444_0004, 1'b0); update_sigs();
        cycle(); chk("fp_idle_grant", obs_deq, 4'b0100);
        chk("fp_issue", issue_valid, 1);

        // asynchronous reset during the immediate fetch
        push(3, 32'h5555_0005, 1'b1);
        push(3, 32'h0000_9999, 1'b0);
        thread_en = 4'b1000; update_sigs();
        cycle(); chk("ar_deq_inst", obs_deq, 4'b1000);
        #2;
        chk("ar_pre_deq", fifo_dequeue_en, 4'b1000);
        reset = 1'b0;
        #1;
        chk("ar_deq", fifo_dequeue_en, 4'b0000);
        chk("ar_valid", issue_valid, 0);
        chk("ar_pvalid", issue_postfix_valid, 0);
        chk("ar_thread", issue_thread, 0);
        chk("ar_inst", issue_inst, 0);
        chk("ar_postfix", issue_postfix, 0);
        chk("ar_count", issue_count, 0);
        @(posedge clk); #1;
        chk("ar_deq_held", fifo_dequeue_en, 4'b0000);
        for (int t = 0; t < N; t++) q[t].delete();
        model_reset();
        update_sigs();
        @(posedge clk); #1;
        reset = 1'b1;

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            thread_en    = 4'($urandom) | 4'($urandom);
            thread_flush = '0;
            if ($urandom_range(0, 19) == 0) thread_flush[$urandom_range(0, N - 1)] = 1'b1;
            issue_ready  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0) begin
                int t;
                t = $urandom_range(0, N - 1);
                if (q[t].size() < 8) begin
                    if ($urandom_range(0, 3) == 0) begin
                        push(t, $urandom, 1'b1);
                        push(t, $urandom, 1'b0);
                    end else begin
                        push(t, $urandom, 1'b0);
                    end
                end
            end
            update_sigs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
